mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer for the single-port 16-bit ram block: cs/read/address/bidirectional data bus, with rdy handshake.
- Accepts read/write requests from two masters: port 0 (instruction fetch) and port 1 (load/store/DMA).
- Grants round-robin, drives the ram bus through its cs -> rdy-low -> rdy-high sequence, returns read data with a one-cycle ack.
- Aborts with an error if the ram handshake stalls.

---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that sequences a single-port ram through its cs/rdy handshake.
// A stalled handshake is aborted after TIMEOUT cycles and flagged with err alongside the ack.
module mem_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 15,
  parameter int TO_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  err,
  output logic                  mem_cs,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_rdy
);

  // state | meaning
  // IDLE  | no access in flight; choose a requester
  // ISSUE | cs high, waiting for the ram to drop rdy
  // WAIT  | ram busy, waiting for rdy to return
  // DONE  | cs held low one cycle, rr pointer moves to the other port
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state;
  logic                  rr;
  logic                  port_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [TO_WIDTH-1:0]   cnt;
  logic                  sel;
  logic                  timed_out;

  // With a single requester it wins outright; the pointer only breaks ties.
  assign sel       = (req0 && req1) ? rr : req1;
  assign timed_out = (cnt == TO_WIDTH'(TIMEOUT - 1));

  assign mem_data = (mem_cs && !mem_read) ? wdata_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr       <= 1'b0;
      port_q   <= 1'b0;
      wdata_q  <= '0;
      cnt      <= '0;
      mem_cs   <= 1'b0;
      mem_read <= 1'b0;
      mem_addr <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err      <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            port_q   <= sel;
            wdata_q  <= sel ? wdata1 : wdata0;
            mem_read <= sel ? ~we1 : ~we0;
            mem_addr <= sel ? addr1 : addr0;
            mem_cs   <= 1'b1;
            cnt      <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (timed_out) begin
            // Counter lands on TIMEOUT and stays there until the next grant clears it.
            mem_cs   <= 1'b0;
            mem_read <= 1'b0;
            cnt      <= TO_WIDTH'(TIMEOUT);
            err      <= 1'b1;
            if (port_q) ack1 <= 1'b1;
            else        ack0 <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
            if (state == ISSUE) begin
              if (!mem_rdy) state <= WAIT;
            end else if (mem_rdy) begin
              // Read data is taken on the same edge that drops cs, while the ram still drives it.
              if (mem_read) begin
                if (port_q) rdata1 <= mem_data;
                else        rdata0 <= mem_data;
              end
              mem_cs   <= 1'b0;
              mem_read <= 1'b0;
              if (port_q) ack1 <= 1'b1;
              else        ack0 <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          rr    <= ~port_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port ram:
// idle --cs--> busy (rdy low) --> done (rdy high, read data driven) --> idle.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        ack0, ack1, err, mem_cs, mem_read;
  logic [15:0] rdata0, rdata1, mem_addr;
  wire  [15:0] mem_data;
  logic        mem_rdy = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .TIMEOUT(15), .TO_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .err(err), .mem_cs(mem_cs), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_rdy(mem_rdy)
  );

  // Ram model; not tied to rst_n so it finishes an abandoned access on its own.
  logic [15:0] ram_mem [0:255];
  int          ram_st = 0;
  logic        ram_rd = 1'b0;
  logic [7:0]  ram_a = '0;
  logic [15:0] ram_q = '0;
  logic        ram_stall = 1'b0;
  int          ram_acc = 0;

  assign mem_data = (ram_st == 2 && ram_rd) ? ram_q : 16'hzzzz;

  always @(posedge clk) begin
    if (ram_stall) begin
      ram_st  <= 0;
      mem_rdy <= 1'b1;
    end else begin
      case (ram_st)
        0: if (mem_cs) begin
          ram_st  <= 1;
          mem_rdy <= 1'b0;
          ram_rd  <= mem_read;
          ram_a   <= mem_addr[7:0];
          ram_acc <= ram_acc + 1;
        end
        1: begin
          if (!ram_rd) ram_mem[ram_a] <= mem_data;
          ram_q   <= ram_mem[ram_a];
          mem_rdy <= 1'b1;
          ram_st  <= 2;
        end
        default: ram_st <= 0;
      endcase
    end
  end

  // Per-transaction observations, gathered at falling edges.
  int          cs_cycles, ack_at, ack0_cnt, ack1_cnt, err_cnt, data_bad, read_bad, addr_bad;
  logic        cs_at_ack, err_at_ack;
  logic [15:0] rd0_at_ack, rd1_at_ack;
  logic [15:0] zz = 16'hzzzz;

  task automatic reset_dut();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_txn(input int port, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input int ncyc);
    cs_cycles = 0; ack_at = 0; ack0_cnt = 0; ack1_cnt = 0; err_cnt = 0;
    data_bad = 0; read_bad = 0; addr_bad = 0;
    cs_at_ack = 1'b1; err_at_ack = 1'b0; rd0_at_ack = '0; rd1_at_ack = '0;
    if (port == 0) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    else           begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (mem_cs) begin
        cs_cycles++;
        if (mem_read !== ~we) read_bad++;
        if (mem_addr !== addr) addr_bad++;
        if (we && mem_data !== wdata) data_bad++;
      end
      ack0_cnt += int'(ack0);
      ack1_cnt += int'(ack1);
      err_cnt  += int'(err);
      if (ack_at == 0 && (ack0 || ack1)) begin
        ack_at = i; cs_at_ack = mem_cs; err_at_ack = err;
        rd0_at_ack = rdata0; rd1_at_ack = rdata1;
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mem_cs !== 1'b0) begin errors++; $display("FAIL reset_cs got %b want 0", mem_cs); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_read got %b want 0", mem_read); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got %h want 0000", mem_addr); end
    checks++; if ({ack0, ack1, err} !== 3'b000) begin errors++; $display("FAIL reset_ack_err got %b want 000", {ack0, ack1, err}); end
    checks++; if ({rdata0, rdata1} !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", {rdata0, rdata1}); end
    checks++; if (mem_data !== zz) begin errors++; $display("FAIL reset_bus got %h want zzzz", mem_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    run_txn(0, 1'b1, 16'h0012, 16'hA5A5, 6);
    checks++; if (cs_cycles !== 3) begin errors++; $display("FAIL wr_cs_len got %0d want 3", cs_cycles); end
    checks++; if (ack_at !== 4) begin errors++; $display("FAIL wr_ack_latency got %0d want 4", ack_at); end
    checks++; if (ack0_cnt !== 1 || ack1_cnt !== 0) begin errors++; $display("FAIL wr_ack_count got %0d/%0d want 1/0", ack0_cnt, ack1_cnt); end
    checks++; if (data_bad !== 0 || read_bad !== 0 || addr_bad !== 0) begin errors++; $display("FAIL wr_bus got data %0d read %0d addr %0d bad want 0", data_bad, read_bad, addr_bad); end
    checks++; if (mem_data !== zz) begin errors++; $display("FAIL wr_bus_release got %h want zzzz", mem_data); end
    checks++; if (ram_mem[8'h12] !== 16'hA5A5) begin errors++; $display("FAIL wr_ram_content got %h want a5a5", ram_mem[8'h12]); end
    run_txn(1, 1'b1, 16'h0001, 16'h1111, 6);
    run_txn(1, 1'b1, 16'h0002, 16'h2222, 6);
    checks++; if (ram_mem[8'h01] !== 16'h1111 || ram_mem[8'h02] !== 16'h2222) begin errors++; $display("FAIL wr_port1 got %h %h want 1111 2222", ram_mem[8'h01], ram_mem[8'h02]); end
  endtask

  task automatic test_read();
    run_txn(1, 1'b0, 16'h0012, 16'h0000, 6);
    checks++; if (rd1_at_ack !== 16'hA5A5) begin errors++; $display("FAIL rd_data got %h want a5a5", rd1_at_ack); end
    checks++; if (ack_at !== 4 || ack1_cnt !== 1 || ack0_cnt !== 0) begin errors++; $display("FAIL rd_ack got at %0d cnt %0d/%0d want 4 0/1", ack_at, ack0_cnt, ack1_cnt); end
    checks++; if (read_bad !== 0 || cs_cycles !== 3) begin errors++; $display("FAIL rd_strobe got bad %0d cs %0d want 0 3", read_bad, cs_cycles); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL rd_err got %0d want 0", err_cnt); end
  endtask

  task automatic test_round_robin();
    int          n = 0, both = 0;
    int          seq [4], at [4];
    logic [15:0] rdv [4];
    reset_dut();
    we0 = 1'b0; we1 = 1'b0; addr0 = 16'h0001; addr1 = 16'h0002;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      if (ack0 && ack1) both++;
      if ((ack0 || ack1) && n < 4) begin
        seq[n] = ack1 ? 1 : 0; at[n] = i; rdv[n] = ack1 ? rdata1 : rdata0; n++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (n !== 4 || both !== 0) begin errors++; $display("FAIL rr_ack_count got %0d both %0d want 4 0", n, both); end
    // 3-cycle access, then one DONE and one IDLE cycle before the next grant.
    for (int k = 0; k < n; k++) begin
      checks++; if (seq[k] !== (k % 2)) begin errors++; $display("FAIL rr_order txn %0d got port %0d want %0d", k, seq[k], k % 2); end
      checks++; if (at[k] !== 4 + 5 * k) begin errors++; $display("FAIL rr_spacing txn %0d got cycle %0d want %0d", k, at[k], 4 + 5 * k); end
      checks++; if (rdv[k] !== ((k % 2) ? 16'h2222 : 16'h1111)) begin errors++; $display("FAIL rr_rdata txn %0d got %h want %h", k, rdv[k], (k % 2) ? 16'h2222 : 16'h1111); end
    end
  endtask

  task automatic test_timeout();
    ram_stall = 1'b1;
    run_txn(0, 1'b0, 16'h0002, 16'h0000, 20);
    ram_stall = 1'b0;
    checks++; if (ack_at !== 16) begin errors++; $display("FAIL to_ack_latency got %0d want 16", ack_at); end
    checks++; if (err_at_ack !== 1'b1 || err_cnt !== 1) begin errors++; $display("FAIL to_err got %b cnt %0d want 1 1", err_at_ack, err_cnt); end
    checks++; if (cs_at_ack !== 1'b0 || cs_cycles !== 15) begin errors++; $display("FAIL to_cs got %b len %0d want 0 15", cs_at_ack, cs_cycles); end
    checks++; if (rd0_at_ack !== 16'h1111 || ack0_cnt !== 1) begin errors++; $display("FAIL to_rdata got %h acks %0d want 1111 1", rd0_at_ack, ack0_cnt); end
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0002;
    repeat (3) @(negedge clk);
    checks++; if (mem_cs !== 1'b1 || mem_rdy !== 1'b1) begin errors++; $display("FAIL rm_in_wait got cs %b rdy %b want 1 1", mem_cs, mem_rdy); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_cs !== 1'b0) begin errors++; $display("FAIL rm_cs_drop got %b want 0", mem_cs); end
    checks++; if (rdata0 !== 16'h0) begin errors++; $display("FAIL rm_rdata got %h want 0000", rdata0); end
    req0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      acks += int'(ack0) + int'(ack1);
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL rm_no_ack got %0d want 0", acks); end
    run_txn(0, 1'b0, 16'h0002, 16'h0000, 6);
    checks++; if (ack_at !== 4 || rd0_at_ack !== 16'h2222) begin errors++; $display("FAIL rm_fresh_read got at %0d data %h want 4 2222", ack_at, rd0_at_ack); end
  endtask

  task automatic test_no_spurious();
    int acc0, idle_bad = 0;
    acc0 = ram_acc;
    run_txn(1, 1'b1, 16'h0003, 16'h3333, 6);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (mem_rdy !== 1'b1 || mem_cs !== 1'b0) idle_bad++;
    end
    checks++; if (ram_acc - acc0 !== 1) begin errors++; $display("FAIL ns_access_count got %0d want 1", ram_acc - acc0); end
    checks++; if (idle_bad !== 0) begin errors++; $display("FAIL ns_idle_rdy got %0d bad cycles want 0", idle_bad); end
    checks++; if (ram_mem[8'h03] !== 16'h3333) begin errors++; $display("FAIL ns_write got %h want 3333", ram_mem[8'h03]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_no_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
